// File: rtl/register_file.sv
// ============================================================================
// register_file : multi-port GPR array with an auto-advancing program counter
// Revision      : 1.0
// ============================================================================
`default_nettype none

module register_file #(
  parameter int               WIDTH      = 32,
  parameter int               ADDR_WIDTH = 4,
  parameter int               PC_INDEX   = 15,
  parameter int               PC_STEP    = 4,
  parameter logic [WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] ra_addr,
  input  logic [ADDR_WIDTH-1:0] rb_addr,
  output logic [WIDTH-1:0]      ra_data,
  output logic [WIDTH-1:0]      rb_data,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic                  pc_advance,
  output logic [WIDTH-1:0]      pc_out
);

  localparam int                    NUM_REGS = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] PC_ADDR  = ADDR_WIDTH'(PC_INDEX);
  localparam logic [WIDTH-1:0]      STEP     = WIDTH'(PC_STEP);
  localparam logic [WIDTH-1:0]      READ_OFS = WIDTH'(2 * PC_STEP);
  localparam logic [WIDTH-1:0]      PC_MASK  = ~(STEP - WIDTH'(1));

  logic [WIDTH-1:0] regs_q [NUM_REGS];
  logic [WIDTH-1:0] regs_d [NUM_REGS];
  logic [WIDTH-1:0] ra_data_q, ra_data_d;
  logic [WIDTH-1:0] rb_data_q, rb_data_d;

  logic             wr_pc;
  logic [WIDTH-1:0] wr_data_eff;
  logic [WIDTH-1:0] pc_q;

  assign pc_q        = regs_q[PC_ADDR];
  assign wr_pc       = we && (wr_addr == PC_ADDR);
  // PC writes are forced to PC_STEP alignment, including on the bypass path.
  assign wr_data_eff = wr_pc ? (wr_data & PC_MASK) : wr_data;

  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_d[i] = regs_q[i];
    end
    if (we) begin
      regs_d[wr_addr] = wr_data_eff;
    end
    if (pc_advance && !wr_pc) begin
      regs_d[PC_ADDR] = pc_q + STEP;
    end
  end

  function automatic logic [WIDTH-1:0] read_sel(input logic [ADDR_WIDTH-1:0] addr);
    logic [WIDTH-1:0] val;
    if (we && (wr_addr == addr)) begin
      val = wr_data_eff;
    end else if (addr == PC_ADDR) begin
      val = pc_q + READ_OFS;
    end else begin
      val = regs_q[addr];
    end
    return val;
  endfunction

  always_comb begin
    ra_data_d = ra_data_q;
    rb_data_d = rb_data_q;
    if (rd_en) begin
      ra_data_d = read_sel(ra_addr);
      rb_data_d = read_sel(rb_addr);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= (i == PC_INDEX) ? RESET_PC : '0;
      end
      ra_data_q <= '0;
      rb_data_q <= '0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
      ra_data_q <= ra_data_d;
      rb_data_q <= rb_data_d;
    end
  end

  assign ra_data = ra_data_q;
  assign rb_data = rb_data_q;
  assign pc_out  = pc_q;

endmodule

`default_nettype wire

// File: tb/tb_register_file.sv
// ============================================================================
// tb_register_file : directed and random checks of register_file vs a model
// Revision         : 1.0
// ============================================================================
`default_nettype none

module tb_register_file;

  logic        clk;
  logic        reset;
  logic        rd_en;
  logic [3:0]  ra_addr;
  logic [3:0]  rb_addr;
  logic [31:0] ra_data;
  logic [31:0] rb_data;
  logic        we;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic        pc_advance;
  logic [31:0] pc_out;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0] mem [16];
  logic [31:0] exp_ra;
  logic [31:0] exp_rb;

  register_file dut (
    .clk        (clk),
    .reset      (reset),
    .rd_en      (rd_en),
    .ra_addr    (ra_addr),
    .rb_addr    (rb_addr),
    .ra_data    (ra_data),
    .rb_data    (rb_data),
    .we         (we),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .pc_advance (pc_advance),
    .pc_out     (pc_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mem[i] = 32'h0;
    exp_ra = 32'h0;
    exp_rb = 32'h0;
  endtask

  function automatic logic [31:0] model_read(input logic [3:0] a, input logic w,
                                             input logic [3:0] wa, input logic [31:0] wv);
    if (w && wa == a) return wv;
    if (a == 4'd15)   return mem[15] + 32'd8;
    return mem[a];
  endfunction

  // Called at a falling edge: drives one cycle, predicts, then checks at the next fall.
  task automatic cycle(input logic ren, input logic [3:0] a, input logic [3:0] b,
                       input logic w, input logic [3:0] wa, input logic [31:0] wd,
                       input logic adv);
    logic [31:0] wv;
    rd_en = ren; ra_addr = a; rb_addr = b;
    we = w; wr_addr = wa; wr_data = wd; pc_advance = adv;
    wv = (wa == 4'd15) ? (wd & 32'hFFFF_FFFC) : wd;
    if (ren) begin
      exp_ra = model_read(a, w, wa, wv);
      exp_rb = model_read(b, w, wa, wv);
    end
    if (w) mem[wa] = wv;
    if (adv && !(w && wa == 4'd15)) mem[15] = mem[15] + 32'd4;
    @(negedge clk);
    check_eq("ra_data", ra_data, exp_ra);
    check_eq("rb_data", rb_data, exp_rb);
    check_eq("pc_out", pc_out, mem[15]);
  endtask

  initial begin
    reset = 1'b0;
    rd_en = 1'b0; ra_addr = '0; rb_addr = '0;
    we = 1'b0; wr_addr = '0; wr_data = '0; pc_advance = 1'b0;
    model_reset();

    #3;
    check_eq("rst_ra", ra_data, 32'h0);
    check_eq("rst_rb", rb_data, 32'h0);
    check_eq("rst_pc", pc_out, 32'h0);

    @(negedge clk);
    reset = 1'b1;

    cycle(1, 4'd3, 4'd15, 0, 4'd0, 32'h0, 0);
    check_eq("rd_r3", ra_data, 32'h0);
    check_eq("rd_r15", rb_data, 32'h8);

    cycle(0, 4'd0, 4'd0, 1, 4'd5, 32'hDEAD_BEEF, 0);
    cycle(1, 4'd5, 4'd5, 0, 4'd0, 32'h0, 0);
    check_eq("wr_rd_a", ra_data, 32'hDEAD_BEEF);
    check_eq("wr_rd_b", rb_data, 32'hDEAD_BEEF);

    cycle(1, 4'd2, 4'd1, 1, 4'd2, 32'h1234_5678, 0);
    check_eq("bypass_a", ra_data, 32'h1234_5678);
    check_eq("bypass_b", rb_data, 32'h0);

    repeat (3) cycle(0, 4'd0, 4'd0, 0, 4'd0, 32'h0, 1);
    check_eq("pc_adv3", pc_out, 32'hC);

    cycle(0, 4'd0, 4'd0, 1, 4'd15, 32'h1003, 1);
    check_eq("pc_prio", pc_out, 32'h1000);

    cycle(0, 4'd0, 4'd0, 1, 4'd15, 32'hFFFF_FFFC, 0);
    cycle(0, 4'd0, 4'd0, 0, 4'd0, 32'h0, 1);
    check_eq("pc_wrap", pc_out, 32'h0);

    cycle(0, 4'd0, 4'd0, 1, 4'd7, 32'hAA, 0);
    cycle(1, 4'd7, 4'd7, 0, 4'd0, 32'h0, 0);
    check_eq("hold_rd", ra_data, 32'hAA);
    cycle(0, 4'd3, 4'd3, 1, 4'd7, 32'hBB, 0);
    check_eq("hold_1", ra_data, 32'hAA);
    cycle(0, 4'd9, 4'd9, 0, 4'd0, 32'h0, 0);
    check_eq("hold_2", ra_data, 32'hAA);
    cycle(1, 4'd7, 4'd7, 0, 4'd0, 32'h0, 0);
    check_eq("hold_new", ra_data, 32'hBB);

    cycle(0, 4'd0, 4'd0, 1, 4'd4, 32'h55, 0);
    cycle(1, 4'd4, 4'd15, 1, 4'd15, 32'h40, 0);
    check_eq("pre_rst_pc", pc_out, 32'h40);
    check_eq("pre_rst_r4", ra_data, 32'h55);
    rd_en = 1'b0; we = 1'b0; pc_advance = 1'b0;
    #1 reset = 1'b0;
    #1;
    check_eq("arst_ra", ra_data, 32'h0);
    check_eq("arst_rb", rb_data, 32'h0);
    check_eq("arst_pc", pc_out, 32'h0);
    #1 reset = 1'b1;
    model_reset();
    @(negedge clk);
    cycle(1, 4'd4, 4'd15, 0, 4'd0, 32'h0, 0);
    check_eq("arst_r4", ra_data, 32'h0);
    check_eq("arst_r15", rb_data, 32'h8);

    for (int n = 0; n < 400; n++) begin
      cycle(1'($urandom_range(0, 3) != 0),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 32'($urandom),
            1'($urandom_range(0, 2) == 0));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/register_file.md
# register_file

Parametrised general-purpose register file for the ARM core. It replaces single-register storage with an array of 2^ADDR_WIDTH registers, two registered read ports, one write port with write-first bypass, and an architectural program counter that auto-advances. It sits between decode (read addresses), the writeback stage (write port) and fetch (`pc_out`).

## Interface
- `WIDTH`, 32: data width of every register.
- `ADDR_WIDTH`, 4: address width; the file holds 2^ADDR_WIDTH registers.
- `PC_INDEX`, 15: register index that acts as the program counter.
- `PC_STEP`, 4: PC increment; must be a power of two and at least 1.
- `RESET_PC`, 0: PC value after reset.

- `clk` input 1: rising-edge clock.
- `reset` input 1: asynchronous, active-low reset.
- `rd_en` input 1: capture the read ports this cycle.
- `ra_addr` input ADDR_WIDTH: read port A address.
- `rb_addr` input ADDR_WIDTH: read port B address.
- `ra_data` output WIDTH: registered read data, port A.
- `rb_data` output WIDTH: registered read data, port B.
- `we` input 1: write enable.
- `wr_addr` input ADDR_WIDTH: write address.
- `wr_data` input WIDTH: write data.
- `pc_advance` input 1: increment the PC by PC_STEP.
- `pc_out` output WIDTH: current PC, driven directly from storage.

## Operation
- Reset (`reset`=0, asynchronous):
  - all registers become 0, except register PC_INDEX, which becomes RESET_PC;
  - `ra_data` and `rb_data` become 0;
  - `pc_out` becomes RESET_PC.
- Write:
  - At a rising edge with `we`=1, register[`wr_addr`] takes `wr_data`.
  - If `wr_addr`=PC_INDEX, the stored value is `wr_data` with its low log2(PC_STEP) bits forced to 0.
- PC advance:
  - At a rising edge with `pc_advance`=1, the PC takes PC + PC_STEP, modulo 2^WIDTH (wraps silently).
  - A write to PC_INDEX in the same cycle has priority; the advance is dropped for that cycle.
- Read, at a rising edge with `rd_en`=1, each port independently loads:
  - `wr_data` if `we`=1 and `wr_addr` equals the port address (write-first bypass; PC alignment masking also applies to a bypassed PC write);
  - otherwise, if the port address is PC_INDEX, PC + 2·PC_STEP modulo 2^WIDTH (the ARM read-PC offset), using the pre-edge PC;
  - otherwise, the stored register value.
- `pc_advance` has no effect on read data captured in the same cycle.
- With `rd_en`=0, `ra_data` and `rb_data` hold their previous values. Writes and PC advance still proceed.
- Both ports may read the same address in the same cycle and return identical values.

## Timing
- Read latency is 1 cycle: addresses are sampled at edge N, and data is valid after edge N and held until the next edge with `rd_en`=1.
- Writes are visible in storage after the edge. A read of the same address at the same edge returns the new data through the bypass, so there is no write-then-read hazard.
- `pc_out` reflects a write or advance immediately after the edge, with no extra pipeline stage.
- Reset asserted mid-operation clears everything asynchronously, independent of `clk`; pending writes are lost.
- On release of reset, the first edge behaves as a normal cycle.

## Test plan
- Reset values: assert `reset`=0 with default parameters. Require `ra_data`=`rb_data`=0 and `pc_out`=0. Release reset and read r3 and r15 with `rd_en`=1; after one edge require `ra_data`=0 and `rb_data`=0x8.
- Write then read: write r5 with 0xDEADBEEF, then on the next cycle read A=r5 and B=r5. Require both ports = 0xDEADBEEF one edge later.
- Bypass: in a single cycle, set `we`=1, `wr_addr`=r2, `wr_data`=0x12345678, `ra_addr`=r2, `rb_addr`=r1 (r1=0). Require `ra_data`=0x12345678 and `rb_data`=0.
- PC advance, priority and wrap:
  - Advance 3 cycles from reset; require `pc_out`=0xC.
  - Assert `pc_advance`=1 together with a write to r15 of 0x1003; require `pc_out`=0x1000.
  - Write r15 with 0xFFFFFFFC, then advance once; require `pc_out`=0.
- Hold: read r7=0xAA with `rd_en`=1, then set `rd_en`=0, write r7=0xBB and change `ra_addr`. Require `ra_data` to stay 0xAA until `rd_en` returns to 1, then show 0xBB.
- Async reset mid-stream: with r4=0x55 and PC=0x40, pulse `reset` low between clock edges. Require immediate clear: `pc_out`=0, outputs 0, and r4 reads 0 afterwards.
